// File: rtl/h80bus_pkg.sv
// Shared definitions for the h80 peripheral bus: command codes, arbiter
// state encoding and command classification.
package h80bus_pkg;

    localparam int BUS_CMD_W = 3;

    localparam logic [BUS_CMD_W-1:0] bus_cmd_nop     = 3'd0;
    localparam logic [BUS_CMD_W-1:0] bus_cmd_read_b  = 3'd1;
    localparam logic [BUS_CMD_W-1:0] bus_cmd_read_w  = 3'd2;
    localparam logic [BUS_CMD_W-1:0] bus_cmd_write_b = 3'd3;
    localparam logic [BUS_CMD_W-1:0] bus_cmd_write_w = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    function automatic logic bus_cmd_is_write(input logic [BUS_CMD_W-1:0] c);
        return (c == bus_cmd_write_b) || (c == bus_cmd_write_w);
    endfunction

endpackage

// File: rtl/h80bus_rr_pick.sv
// Two-way round-robin winner select; the priority pointer moves to the
// losing side whenever a grant is taken.
module h80bus_rr_pick (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] win
);

    logic prio_q, prio_d;

    always_comb begin
        win    = req;
        prio_d = prio_q;
        if (req == 2'b11) begin
            win = prio_q ? 2'b10 : 2'b01;
        end
        // Master 0 winning hands priority to master 1, and vice versa.
        if (take && (|req)) begin
            prio_d = win[0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/h80bus_arbiter.sv
// Two-master arbiter and IDLE/ACCESS/RELEASE cycle sequencer for the h80 bus.
// Optional wait_n timeout abort is enabled by defining H80BUS_ARB_TIMEOUT_EN.
module h80bus_arbiter
    import h80bus_pkg::*;
#(
    parameter int BUS_ADDR_WIDTH = 16,
    parameter int BUS_CMD_WIDTH  = 3,
    parameter int BUS_DATA_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [1:0]                     m_req,
    input  logic [1:0][BUS_ADDR_WIDTH-1:0] m_addr,
    input  logic [1:0][BUS_CMD_WIDTH-1:0]  m_cmd,
    input  logic [1:0][BUS_DATA_WIDTH-1:0] m_wdata,
    output logic [1:0]                     m_gnt,
    output logic [1:0]                     m_done,
    output logic [BUS_DATA_WIDTH-1:0]      m_rdata,
    output logic                           m_err,
    output logic                           ce_n,
    output logic [BUS_ADDR_WIDTH-1:0]      addr,
    output logic [BUS_CMD_WIDTH-1:0]       cmd,
    inout  wire  [BUS_DATA_WIDTH-1:0]      data,
    input  logic                           wait_n
);

    arb_state_e                state_q, state_d;
    logic [1:0]                gnt_q, gnt_d;
    logic [BUS_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_CMD_WIDTH-1:0]  cmd_q, cmd_d;
    logic [BUS_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BUS_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;

    logic [1:0] win;
    logic       take;
    logic       is_wr;
    logic       timed_out;

    assign take  = (state_q == ST_IDLE) && (|m_req);
    assign is_wr = bus_cmd_is_write(BUS_CMD_W'(cmd_q));

    h80bus_rr_pick u_rr_pick (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (m_req),
        .take    (take),
        .win     (win)
    );

`ifdef H80BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts wait_n-low cycles of the current access; zero outside ACCESS.
    always_comb begin
        cnt_d = '0;
        if (state_q == ST_ACCESS && !wait_n) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timed_out = (state_q == ST_ACCESS) && !wait_n &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign timed_out      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        cmd_d   = cmd_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    gnt_d   = win;
                    addr_d  = m_addr[win[1]];
                    cmd_d   = m_cmd[win[1]];
                    wdata_d = m_wdata[win[1]];
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (timed_out) begin
                    rdata_d = '1;
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end else if (wait_n) begin
                    rdata_d = is_wr ? '0 : data;
                    err_d   = 1'b0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Turnaround cycle: grant drops as we return to IDLE.
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            addr_q  <= '0;
            cmd_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Slave-side strobes decode straight from the state flop so reset frees the bus at once.
    assign ce_n    = (state_q != ST_ACCESS);
    assign addr    = (state_q == ST_ACCESS) ? addr_q : '0;
    assign cmd     = (state_q == ST_ACCESS) ? cmd_q : '0;
    assign data    = ((state_q == ST_ACCESS) && is_wr) ? wdata_q : 'z;
    assign m_gnt   = gnt_q;
    assign m_done  = (state_q == ST_RELEASE) ? gnt_q : 2'b00;
    assign m_rdata = rdata_q;
    assign m_err   = err_q;

endmodule

// File: tb/tb_h80bus_arbiter.sv
// Self-checking bench for h80bus_arbiter: directed scenarios plus randomized
// two-master traffic against a transaction-level model with an acting slave.
module tb_h80bus_arbiter;
    import h80bus_pkg::*;

    localparam int AW = 16;
    localparam int CW = 3;
    localparam int DW = 16;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [1:0]             m_req;
    logic [1:0][AW-1:0]     m_addr;
    logic [1:0][CW-1:0]     m_cmd;
    logic [1:0][DW-1:0]     m_wdata;
    logic [1:0]             m_gnt;
    logic [1:0]             m_done;
    logic [DW-1:0]          m_rdata;
    logic                   m_err;
    logic                   ce_n;
    logic [AW-1:0]          addr;
    logic [CW-1:0]          cmd;
    wire  [DW-1:0]          data;
    logic                   wait_n;
    logic [DW-1:0]          slv_val;

    int nvec = 0;
    int nerr = 0;

    // Transaction-level model: per-master pending request and a priority owner.
    bit          pend [2];
    logic [15:0] ta   [2];
    logic [2:0]  tc   [2];
    logic [15:0] tw   [2];
    int          prio;
    logic [15:0] last_rdata;

    h80bus_arbiter #(
        .BUS_ADDR_WIDTH (AW),
        .BUS_CMD_WIDTH  (CW),
        .BUS_DATA_WIDTH (DW),
`ifdef H80BUS_ARB_TIMEOUT_EN
        .TIMEOUT_CYCLES (4)
`else
        .TIMEOUT_CYCLES (255)
`endif
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .m_req   (m_req),
        .m_addr  (m_addr),
        .m_cmd   (m_cmd),
        .m_wdata (m_wdata),
        .m_gnt   (m_gnt),
        .m_done  (m_done),
        .m_rdata (m_rdata),
        .m_err   (m_err),
        .ce_n    (ce_n),
        .addr    (addr),
        .cmd     (cmd),
        .data    (data),
        .wait_n  (wait_n)
    );

    // Undriven bus reads as all ones, which is how high-Z is observed.
    for (genvar i = 0; i < DW; i++) begin : g_pu
        pullup (data[i]);
    end

    // Slave: drives read data while selected with a non-write command.
    assign data = (!ce_n && !bus_cmd_is_write(cmd)) ? slv_val : 'z;

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        m_req = {pend[1], pend[0]};
        for (int m = 0; m < 2; m++) begin
            m_addr[m]  = ta[m];
            m_cmd[m]   = tc[m];
            m_wdata[m] = tw[m];
        end
    endtask

    // Called at a negedge in IDLE with at least one pending request.
    task automatic do_txn(input int nw, input bit drop, input logic [15:0] sv);
        int   win;
        bit   wr;
        logic [1:0] g;
        drive_reqs();
        win  = (pend[0] && pend[1]) ? prio : (pend[0] ? 0 : 1);
        prio = 1 - win;
        g    = (win == 0) ? 2'b01 : 2'b10;
        wr   = (tc[win] == bus_cmd_write_b) || (tc[win] == bus_cmd_write_w);
        slv_val = sv;
        @(negedge clk);
        for (int k = 0; k <= nw; k++) begin
            wait_n = (k == nw);
            if (k == 0 && drop) m_req[win] = 1'b0;
            chk("acc_ce_n", ce_n, 0);
            chk("acc_gnt", m_gnt, g);
            chk("acc_done", m_done, 0);
            chk("acc_addr", addr, ta[win]);
            chk("acc_cmd", cmd, tc[win]);
            chk("acc_data", data, wr ? tw[win] : sv);
            @(negedge clk);
        end
        last_rdata = wr ? 16'h0000 : sv;
        chk("rel_ce_n", ce_n, 1);
        chk("rel_addr", addr, 0);
        chk("rel_cmd", cmd, 0);
        chk("rel_data_hiz", data, 16'hFFFF);
        chk("rel_done", m_done, g);
        chk("rel_gnt", m_gnt, g);
        chk("rel_rdata", m_rdata, last_rdata);
        chk("rel_err", m_err, 0);
        pend[win]  = 1'b0;
        m_req[win] = 1'b0;
        @(negedge clk);
        chk("idle_ce_n", ce_n, 1);
        chk("idle_gnt", m_gnt, 0);
        chk("idle_done", m_done, 0);
        chk("idle_rdata_hold", m_rdata, last_rdata);
        chk("idle_data_hiz", data, 16'hFFFF);
    endtask

    task automatic set_req(input int m, input logic [15:0] a, input logic [2:0] c,
                           input logic [15:0] w);
        pend[m] = 1'b1;
        ta[m]   = a;
        tc[m]   = c;
        tw[m]   = w;
    endtask

    initial begin
        logic [1:0] seen [4];
        bit         stuck_ok;
        reset_n = 1'b0;
        m_req   = '0;
        m_addr  = '0;
        m_cmd   = '0;
        m_wdata = '0;
        wait_n  = 1'b1;
        slv_val = '0;
        prio    = 0;
        last_rdata = '0;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 1'b0; ta[m] = '0; tc[m] = '0; tw[m] = '0;
        end

        // Reset state
        #12;
        chk("rst_ce_n", ce_n, 1);
        chk("rst_addr", addr, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_data_hiz", data, 16'hFFFF);
        chk("rst_gnt", m_gnt, 0);
        chk("rst_done", m_done, 0);
        chk("rst_rdata", m_rdata, 0);
        chk("rst_err", m_err, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Single read by master 0
        set_req(0, 16'h0000, bus_cmd_read_w, 16'h0000);
        do_txn(0, 1'b0, 16'h00A5);
        chk("read_rdata", m_rdata, 16'h00A5);

        // Write with three wait cycles by master 1
        set_req(1, 16'h0000, bus_cmd_write_b, 16'h0041);
        do_txn(3, 1'b0, 16'h5A5A);
        chk("write_rdata_zero", m_rdata, 16'h0000);

        // Contention: both masters keep requesting for four transactions
        for (int t = 0; t < 4; t++) begin
            if (!pend[0]) set_req(0, 16'h1000 + 16'(t), bus_cmd_read_b, 16'h1111);
            if (!pend[1]) set_req(1, 16'h2000 + 16'(t), bus_cmd_write_w, 16'h2222);
            drive_reqs();
            @(negedge clk);
            seen[t] = m_gnt;
            @(posedge clk);
            #1;
            // Re-align: do_txn expects to start from IDLE, so finish this one by hand.
            wait_n = 1'b1;
            @(negedge clk);
            chk("cont_done", m_done, seen[t]);
            pend[seen[t][1]] = 1'b0;
            prio = seen[t][1] ? 0 : 1;
            @(negedge clk);
            chk("cont_gap_ce_n", ce_n, 1);
        end
        chk("cont_gnt0", seen[0], 2'b01);
        chk("cont_gnt1", seen[1], 2'b10);
        chk("cont_gnt2", seen[2], 2'b01);
        chk("cont_gnt3", seen[3], 2'b10);
        pend[0] = 1'b0; pend[1] = 1'b0;
        m_req = '0;
        @(negedge clk);

        // Randomized traffic, commit rule exercised by random early drops
        for (int t = 0; t < 80; t++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && $urandom_range(0, 2) != 0) begin
                    set_req(m, 16'($urandom), 3'($urandom_range(0, 7)), 16'($urandom));
                end
            end
            if (!pend[0] && !pend[1]) begin
                m_req = '0;
                @(negedge clk);
                chk("rnd_idle_ce_n", ce_n, 1);
                chk("rnd_idle_gnt", m_gnt, 0);
            end else begin
                do_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), 16'($urandom));
            end
        end
        pend[0] = 1'b0; pend[1] = 1'b0;
        m_req = '0;
        @(negedge clk);

        // Stuck wait_n
        set_req(0, 16'h00F0, bus_cmd_read_w, 16'h0000);
        drive_reqs();
        slv_val = 16'h1234;
        @(negedge clk);
        wait_n = 1'b0;
`ifdef H80BUS_ARB_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            chk("tmo_acc_ce_n", ce_n, 0);
            @(negedge clk);
        end
        chk("tmo_done", m_done, 2'b01);
        chk("tmo_err", m_err, 1);
        chk("tmo_rdata", m_rdata, 16'hFFFF);
        chk("tmo_ce_n", ce_n, 1);
        pend[0] = 1'b0;
        prio    = 1;
        m_req   = '0;
        wait_n  = 1'b1;
        @(negedge clk);
        set_req(1, 16'h0042, bus_cmd_read_b, 16'h0000);
        do_txn(0, 1'b0, 16'h0077);
`else
        stuck_ok = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            if (ce_n !== 1'b0 || m_done !== 2'b00 || m_err !== 1'b0) stuck_ok = 1'b0;
            @(negedge clk);
        end
        chk("stuck_in_access", stuck_ok, 1);
        reset_n = 1'b0;
        #1;
        chk("stuck_rst_ce_n", ce_n, 1);
        @(negedge clk);
        reset_n = 1'b1;
        wait_n  = 1'b1;
        pend[0] = 1'b0;
        m_req   = '0;
        prio    = 0;
        @(negedge clk);
`endif

        // Reset mid-access: master 0 write stretched, then async reset
        set_req(0, 16'h0ABC, bus_cmd_write_w, 16'h1234);
        drive_reqs();
        @(negedge clk);
        wait_n = 1'b0;
        chk("mid_acc_ce_n", ce_n, 0);
        chk("mid_acc_data", data, 16'h1234);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ce_n", ce_n, 1);
        chk("mid_rst_data_hiz", data, 16'hFFFF);
        chk("mid_rst_done", m_done, 0);
        chk("mid_rst_gnt", m_gnt, 0);
        @(negedge clk);
        chk("mid_rst_no_done", m_done, 0);
        reset_n = 1'b1;
        wait_n  = 1'b1;
        prio    = 0;
        set_req(1, 16'h0300, bus_cmd_read_w, 16'h0000);
        do_txn(1, 1'b0, 16'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
